riscv_pma_cfg_regs: RTL and testbench
=====================================

// Module: riscv_pma_cfg_regs
// PURPOSE
//  PMA configuration register bank: the writer/owner side of the pma_cfg/pma_adr arrays consumed by the PMA checkers.
//  Software/debug writes go to shadow registers over a simple register port; a commit handshake stalls the memory
//  pipeline until it is idle, then copies shadow->active atomically so checkers never see a half-updated region map.
// PARAMETERS
//  XLEN        32                 data/address width of pma_adr entries and register port data
//  PMA_CNT     16                 number of PMA entries
//  PMA_CFG_RST '{default:0}       pmacfg_t [PMA_CNT] reset value of shadow and active cfg
//  PMA_ADR_RST '{default:0}       [XLEN-1:0] [PMA_CNT] reset value of shadow and active adr
// PORTS
//  clk_i          in   1               clock
//  rst_i          in   1               synchronous reset, active-high
//  reg_req_i      in   1               register access request (held until reg_ack_o)
//  reg_we_i       in   1               1=write, 0=read
//  reg_adr_i      in   AW              word index, AW=$clog2(2*PMA_CNT+2)
//  reg_wdata_i    in   XLEN            write data
//  reg_ack_o      out  1               1-cycle access completion pulse
//  reg_err_o      out  1               valid with ack; access rejected, no state change
//  reg_rdata_o    out  XLEN            read data, valid with ack
//  pipe_idle_i    in   1               memory pipeline has no access in flight
//  cfg_hold_o     out  1               request pipeline to stop issuing accesses
//  cfg_updated_o  out  1               1-cycle pulse: new active values visible this cycle
//  pma_cfg_o      out  pmacfg_t[PMA_CNT]  active configuration (to checkers' pma_cfg_i)
//  pma_adr_o      out  XLEN[PMA_CNT]      active addresses (to checkers' pma_adr_i)
// BEHAVIOUR
//  Clock is clk_i; reset rst_i is synchronous, active-high. Reset: FSM=IDLE, ack/err/hold/updated=0, rdata=0,
//   shadow and active regs = PMA_CFG_RST/PMA_ADR_RST. Reset overrides everything, incl. mid-commit (no partial copy).
//  Map: 0..PMA_CNT-1 cfg[i] (low $bits(pmacfg_t) bits, upper bits write-ignored/read 0); PMA_CNT..2*PMA_CNT-1 adr[i];
//   2*PMA_CNT CTRL (W bit0=commit; R bit0=0, bit1=busy); 2*PMA_CNT+1 LOCK. Index > 2*PMA_CNT+1 -> err.
//  Handshake: access accepted when reg_req_i & ~reg_ack_o; ack (+err/rdata) registered, asserted next cycle exactly
//   once; a still-asserted req on the ack cycle is not re-accepted. Max throughput one access per 2 cycles.
//  Reads always allowed in any state; cfg/adr reads return SHADOW values.
//  FSM IDLE: write CTRL bit0=1 -> WAIT_IDLE (CTRL write with bit0=0 acks, no effect).
//   WAIT_IDLE: cfg_hold_o=1; pipe_idle_i=1 -> COMMIT; waits indefinitely otherwise.
//   COMMIT: cfg_hold_o=1; on this edge active<=shadow for all entries -> IDLE; next cycle cfg_updated_o=1, hold=0.
//   Min commit latency: CTRL write accepted cycle N, ack N+1 (WAIT_IDLE), COMMIT N+2, outputs/updated N+3.
//  While FSM != IDLE: writes to cfg/adr/CTRL/LOCK -> err=1, no change; busy=1.
//  pma_cfg_o/pma_adr_o change only in the cycle after COMMIT; never otherwise (except reset).
// CONFIGURATION
//  RV12_PMA_LOCK_EN defined: LOCK reg bits[PMA_CNT-1:0] set-only (write 1 sets, 0 ignored), cleared only by reset.
//   Write to cfg[i]/adr[i] with lock[i]=1 -> err. Also adr[i-1] write -> err if lock[i]=1 and shadow cfg[i].a==TOR.
//  RV12_PMA_LOCK_EN undefined: LOCK reads 0, writes ack without err and no effect; no entry write is lock-rejected.
// TESTING
//  Reset: pma_cfg_o==PMA_CFG_RST, pma_adr_o==PMA_ADR_RST, ack/err/hold/updated=0, CTRL reads 0.
//  Write adr[3]=0x2000_0FFF, cfg[3].a=NAPOT; read back shadow values; pma_adr_o[3] unchanged until commit.
//  Commit with pipe_idle_i=0 for 5 cycles: hold=1, outputs stable, busy=1; raise idle -> outputs update 2 cycles later, updated 1-cycle pulse, hold=0.
//  Write cfg[0] or LOCK during WAIT_IDLE -> ack with err=1, shadow unchanged; read cfg[0] still ok, err=0.
//  Access index 2*PMA_CNT+2 -> err=1; assert rst_i in WAIT_IDLE -> IDLE, hold=0, outputs=reset values.
//  LOCK_EN: set lock[3], cfg[3].a=TOR; write cfg[3] and adr[2] -> err; adr[4] ok; without macro LOCK reads 0, writes no err.

Source files
------------

// File: rtl/riscv_pma_cfg_regs.sv
// PMA configuration register bank: shadow registers written over a simple register port,
// atomically committed to the active pma_cfg/pma_adr arrays once the memory pipeline is idle.
// Optional feature macro: RV12_PMA_LOCK_EN (per-entry set-only lock bits).

package riscv_pma_cfg_pkg;
    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmacfg_a_t;

    typedef struct packed {
        logic [1:0] mem_type;
        logic       r;
        logic       w;
        logic       x;
        logic       c;
        logic       cc;
        logic       ri;
        logic       wi;
        logic       m;
        logic [1:0] amo_type;
        pmacfg_a_t  a;
    } pmacfg_t;
endpackage

module riscv_pma_cfg_regs
    import riscv_pma_cfg_pkg::*;
#(
    parameter int                           XLEN        = 32,
    parameter int                           PMA_CNT     = 16,
    parameter pmacfg_t [PMA_CNT-1:0]        PMA_CFG_RST = '0,
    parameter logic [PMA_CNT-1:0][XLEN-1:0] PMA_ADR_RST = '0,
    localparam int                          AW          = $clog2(2*PMA_CNT+2)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           reg_req_i,
    input  logic                           reg_we_i,
    input  logic [AW-1:0]                  reg_adr_i,
    input  logic [XLEN-1:0]                reg_wdata_i,
    output logic                           reg_ack_o,
    output logic                           reg_err_o,
    output logic [XLEN-1:0]                reg_rdata_o,
    input  logic                           pipe_idle_i,
    output logic                           cfg_hold_o,
    output logic                           cfg_updated_o,
    output pmacfg_t [PMA_CNT-1:0]          pma_cfg_o,
    output logic [PMA_CNT-1:0][XLEN-1:0]   pma_adr_o
);

    localparam int IW    = (PMA_CNT > 1) ? $clog2(PMA_CNT) : 1;
    localparam int CFG_W = $bits(pmacfg_t);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_COMMIT    = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    pmacfg_t [PMA_CNT-1:0]          shd_cfg_q, act_cfg_q;
    logic [PMA_CNT-1:0][XLEN-1:0]   shd_adr_q, act_adr_q;
    logic                           ack_q, err_q, hold_q, upd_q;
    logic [XLEN-1:0]                rdata_q;

    logic                           accept_s, busy_s, wr_ok_s;
    logic                           is_cfg_s, is_adr_s, is_ctrl_s, is_lock_s, bad_s;
    logic                           locked_s;
    logic [AW-1:0]                  adr_off_s;
    logic [IW-1:0]                  idx_s;
    logic [XLEN-1:0]                lock_rd_s;
    logic                           err_d;
    logic [XLEN-1:0]                rdata_d;

    // Address decode of the register map
    always_comb begin
        adr_off_s = reg_adr_i - AW'(PMA_CNT);
        is_cfg_s  = (reg_adr_i < AW'(PMA_CNT));
        is_adr_s  = ~is_cfg_s & (reg_adr_i < AW'(2*PMA_CNT));
        is_ctrl_s = (reg_adr_i == AW'(2*PMA_CNT));
        is_lock_s = (reg_adr_i == AW'(2*PMA_CNT+1));
        bad_s     = (reg_adr_i > AW'(2*PMA_CNT+1));
        if (is_cfg_s) begin
            idx_s = IW'(reg_adr_i);
        end else begin
            idx_s = IW'(adr_off_s);
        end
    end

`ifdef RV12_PMA_LOCK_EN
    logic [PMA_CNT-1:0] lock_q;
    logic [IW-1:0]      nxt_s;

    // Lock check; a TOR entry's base lives in the previous adr register, so that is covered too
    always_comb begin
        nxt_s     = idx_s + IW'(1);
        lock_rd_s = XLEN'(lock_q);
        locked_s  = 1'b0;
        if (is_cfg_s) begin
            locked_s = lock_q[idx_s];
        end else if (is_adr_s) begin
            if (lock_q[idx_s]) begin
                locked_s = 1'b1;
            end else if ((int'(idx_s) < PMA_CNT-1) && lock_q[nxt_s] &&
                         (shd_cfg_q[nxt_s].a == A_TOR)) begin
                locked_s = 1'b1;
            end else begin
                locked_s = 1'b0;
            end
        end else begin
            locked_s = 1'b0;
        end
    end

    // Set-only lock bits, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= '0;
        end else if (wr_ok_s && is_lock_s) begin
            lock_q <= lock_q | reg_wdata_i[PMA_CNT-1:0];
        end else begin
            lock_q <= lock_q;
        end
    end
`else
    // Lock feature absent: nothing is ever locked, LOCK reads zero
    always_comb begin
        locked_s  = 1'b0;
        lock_rd_s = '0;
    end
`endif

    // Access acceptance, error and read-data generation
    always_comb begin
        accept_s = reg_req_i & ~ack_q;
        busy_s   = (state_q != ST_IDLE);
        wr_ok_s  = accept_s & reg_we_i & ~bad_s & ~busy_s & ~locked_s;
        err_d    = 1'b0;
        rdata_d  = '0;
        if (!accept_s) begin
            err_d = 1'b0;
        end else if (bad_s) begin
            err_d = 1'b1;
        end else if (reg_we_i) begin
            err_d = busy_s | locked_s;
        end else begin
            if (is_cfg_s) begin
                rdata_d = XLEN'(shd_cfg_q[idx_s]);
            end else if (is_adr_s) begin
                rdata_d = shd_adr_q[idx_s];
            end else if (is_ctrl_s) begin
                rdata_d = {{(XLEN-2){1'b0}}, busy_s, 1'b0};
            end else begin
                rdata_d = lock_rd_s;
            end
        end
    end

    // Commit FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ok_s && is_ctrl_s && reg_wdata_i[0]) begin
                    state_d = ST_WAIT_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (pipe_idle_i) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, handshake outputs, shadow writes and shadow->active copy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            upd_q     <= 1'b0;
            rdata_q   <= '0;
            shd_cfg_q <= PMA_CFG_RST;
            act_cfg_q <= PMA_CFG_RST;
            shd_adr_q <= PMA_ADR_RST;
            act_adr_q <= PMA_ADR_RST;
        end else begin
            state_q <= state_d;
            ack_q   <= accept_s;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            hold_q  <= (state_d != ST_IDLE);
            upd_q   <= (state_q == ST_COMMIT);
            if (wr_ok_s && is_cfg_s) begin
                shd_cfg_q[idx_s] <= pmacfg_t'(reg_wdata_i[CFG_W-1:0]);
            end
            if (wr_ok_s && is_adr_s) begin
                shd_adr_q[idx_s] <= reg_wdata_i;
            end
            if (state_q == ST_COMMIT) begin
                act_cfg_q <= shd_cfg_q;
                act_adr_q <= shd_adr_q;
            end
        end
    end

    assign reg_ack_o     = ack_q;
    assign reg_err_o     = err_q;
    assign reg_rdata_o   = rdata_q;
    assign cfg_hold_o    = hold_q;
    assign cfg_updated_o = upd_q;
    assign pma_cfg_o     = act_cfg_q;
    assign pma_adr_o     = act_adr_q;

endmodule

// File: tb/tb_riscv_pma_cfg_regs.sv
// Directed self-checking bench for riscv_pma_cfg_regs (default PMA_CNT=16, XLEN=32).
// Build with RV12_PMA_LOCK_EN defined to exercise the lock feature.

module tb_riscv_pma_cfg_regs;
    import riscv_pma_cfg_pkg::*;

    localparam int XLEN    = 32;
    localparam int PMA_CNT = 16;
    localparam int AW      = $clog2(2*PMA_CNT+2);
    localparam int I_CTRL  = 2*PMA_CNT;
    localparam int I_LOCK  = 2*PMA_CNT+1;

    logic                          clk = 1'b0;
    logic                          rst_i = 1'b1;
    logic                          reg_req_i = 1'b0;
    logic                          reg_we_i = 1'b0;
    logic [AW-1:0]                 reg_adr_i = '0;
    logic [XLEN-1:0]               reg_wdata_i = '0;
    logic                          reg_ack_o, reg_err_o;
    logic [XLEN-1:0]               reg_rdata_o;
    logic                          pipe_idle_i = 1'b1;
    logic                          cfg_hold_o, cfg_updated_o;
    pmacfg_t [PMA_CNT-1:0]         pma_cfg_o;
    logic [PMA_CNT-1:0][XLEN-1:0]  pma_adr_o;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] rd;
    logic            er;

    always #5 clk = ~clk;

    riscv_pma_cfg_regs #(.XLEN(XLEN), .PMA_CNT(PMA_CNT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_adr_i(reg_adr_i),
        .reg_wdata_i(reg_wdata_i), .reg_ack_o(reg_ack_o), .reg_err_o(reg_err_o),
        .reg_rdata_o(reg_rdata_o), .pipe_idle_i(pipe_idle_i),
        .cfg_hold_o(cfg_hold_o), .cfg_updated_o(cfg_updated_o),
        .pma_cfg_o(pma_cfg_o), .pma_adr_o(pma_adr_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One register access; returns sampled just after the ack edge, request dropped.
    task automatic access(input logic we, input int idx, input logic [XLEN-1:0] wd,
                          output logic [XLEN-1:0] rdata, output logic err);
        bit got;
        got = 1'b0;
        @(negedge clk);
        reg_req_i   = 1'b1;
        reg_we_i    = we;
        reg_adr_i   = AW'(idx);
        reg_wdata_i = wd;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (reg_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("ack_timeout", 64'd0, 64'd1);
        rdata     = reg_rdata_o;
        err       = reg_err_o;
        reg_req_i = 1'b0;
        reg_we_i  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_eq("rst_ack", 64'(reg_ack_o), 64'd0);
        check_eq("rst_err", 64'(reg_err_o), 64'd0);
        check_eq("rst_hold", 64'(cfg_hold_o), 64'd0);
        check_eq("rst_upd", 64'(cfg_updated_o), 64'd0);
        check_eq("rst_cfg_o", 64'(pma_cfg_o[3]), 64'd0);
        check_eq("rst_adr_o", 64'(pma_adr_o[3]), 64'd0);
        access(1'b0, I_CTRL, 32'h0, rd, er);
        check_eq("rst_ctrl_rd", 64'(rd), 64'd0);
        check_eq("rst_ctrl_err", 64'(er), 64'd0);

        // Shadow writes and readback; active untouched
        access(1'b1, PMA_CNT+3, 32'h2000_0FFF, rd, er);
        check_eq("wr_adr3_err", 64'(er), 64'd0);
        access(1'b1, 3, 32'hFFFF_0C03, rd, er);
        check_eq("wr_cfg3_err", 64'(er), 64'd0);
        access(1'b0, 3, 32'h0, rd, er);
        check_eq("rd_cfg3", 64'(rd), 64'h0C03);
        access(1'b0, PMA_CNT+3, 32'h0, rd, er);
        check_eq("rd_adr3", 64'(rd), 64'h2000_0FFF);
        check_eq("adr_o3_pre", 64'(pma_adr_o[3]), 64'd0);
        check_eq("cfg_o3_pre", 64'(pma_cfg_o[3]), 64'd0);

        // Commit stalled by busy pipeline
        pipe_idle_i = 1'b0;
        access(1'b1, I_CTRL, 32'h1, rd, er);
        check_eq("commit_err", 64'(er), 64'd0);
        check_eq("commit_hold", 64'(cfg_hold_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("wait_hold", 64'(cfg_hold_o), 64'd1);
            check_eq("wait_adr_o3", 64'(pma_adr_o[3]), 64'd0);
        end
        access(1'b0, I_CTRL, 32'h0, rd, er);
        check_eq("busy_rd", 64'(rd), 64'd2);
        access(1'b1, 0, 32'h0000_0FFF, rd, er);
        check_eq("busy_wr_cfg0_err", 64'(er), 64'd1);
        access(1'b1, I_LOCK, 32'hFFFF_FFFF, rd, er);
        check_eq("busy_wr_lock_err", 64'(er), 64'd1);
        access(1'b1, PMA_CNT+3, 32'h1111_1111, rd, er);
        check_eq("busy_wr_adr3_err", 64'(er), 64'd1);
        access(1'b0, 0, 32'h0, rd, er);
        check_eq("busy_rd_cfg0", 64'(rd), 64'd0);
        check_eq("busy_rd_cfg0_err", 64'(er), 64'd0);
        access(1'b0, PMA_CNT+3, 32'h0, rd, er);
        check_eq("busy_rd_adr3", 64'(rd), 64'h2000_0FFF);

        pipe_idle_i = 1'b1;
        tick();
        check_eq("commit_st_hold", 64'(cfg_hold_o), 64'd1);
        check_eq("commit_st_upd", 64'(cfg_updated_o), 64'd0);
        check_eq("commit_st_adr_o3", 64'(pma_adr_o[3]), 64'd0);
        tick();
        check_eq("upd_pulse", 64'(cfg_updated_o), 64'd1);
        check_eq("upd_hold", 64'(cfg_hold_o), 64'd0);
        check_eq("upd_adr_o3", 64'(pma_adr_o[3]), 64'h2000_0FFF);
        check_eq("upd_cfg_o3", 64'(pma_cfg_o[3]), 64'h0C03);
        tick();
        check_eq("upd_pulse_end", 64'(cfg_updated_o), 64'd0);
        check_eq("post_adr_o3", 64'(pma_adr_o[3]), 64'h2000_0FFF);

        // CTRL write with bit0=0 has no effect
        access(1'b1, I_CTRL, 32'h0, rd, er);
        check_eq("ctrl0_err", 64'(er), 64'd0);
        tick();
        check_eq("ctrl0_hold", 64'(cfg_hold_o), 64'd0);

        // Minimum-latency commit
        access(1'b1, PMA_CNT+5, 32'h0000_1234, rd, er);
        access(1'b1, I_CTRL, 32'h1, rd, er);
        check_eq("min_n1_upd", 64'(cfg_updated_o), 64'd0);
        check_eq("min_n1_adr_o5", 64'(pma_adr_o[5]), 64'd0);
        tick();
        check_eq("min_n2_hold", 64'(cfg_hold_o), 64'd1);
        check_eq("min_n2_adr_o5", 64'(pma_adr_o[5]), 64'd0);
        tick();
        check_eq("min_n3_upd", 64'(cfg_updated_o), 64'd1);
        check_eq("min_n3_adr_o5", 64'(pma_adr_o[5]), 64'h1234);

        // Out-of-range index
        access(1'b0, 2*PMA_CNT+2, 32'h0, rd, er);
        check_eq("bad_rd_err", 64'(er), 64'd1);
        check_eq("bad_rd_data", 64'(rd), 64'd0);
        access(1'b1, 2*PMA_CNT+2, 32'h1, rd, er);
        check_eq("bad_wr_err", 64'(er), 64'd1);

`ifdef RV12_PMA_LOCK_EN
        access(1'b1, 3, 32'h0000_0C01, rd, er);
        check_eq("lk_cfg3_tor_err", 64'(er), 64'd0);
        access(1'b1, I_LOCK, 32'h0000_0008, rd, er);
        check_eq("lk_set_err", 64'(er), 64'd0);
        access(1'b0, I_LOCK, 32'h0, rd, er);
        check_eq("lk_rd", 64'(rd), 64'h8);
        access(1'b1, 3, 32'h0000_0003, rd, er);
        check_eq("lk_cfg3_err", 64'(er), 64'd1);
        access(1'b1, PMA_CNT+2, 32'h5555_0000, rd, er);
        check_eq("lk_adr2_err", 64'(er), 64'd1);
        access(1'b1, PMA_CNT+4, 32'h6666_0000, rd, er);
        check_eq("lk_adr4_err", 64'(er), 64'd0);
        access(1'b1, I_LOCK, 32'h0, rd, er);
        access(1'b0, I_LOCK, 32'h0, rd, er);
        check_eq("lk_setonly", 64'(rd), 64'h8);
        access(1'b0, 3, 32'h0, rd, er);
        check_eq("lk_cfg3_kept", 64'(rd), 64'h0C01);
`else
        access(1'b1, I_LOCK, 32'h0000_FFFF, rd, er);
        check_eq("nolk_wr_err", 64'(er), 64'd0);
        access(1'b0, I_LOCK, 32'h0, rd, er);
        check_eq("nolk_rd", 64'(rd), 64'd0);
        access(1'b1, 3, 32'h0000_0C01, rd, er);
        check_eq("nolk_cfg3_err", 64'(er), 64'd0);
        access(1'b1, PMA_CNT+2, 32'h5555_0000, rd, er);
        check_eq("nolk_adr2_err", 64'(er), 64'd0);
        access(1'b0, PMA_CNT+2, 32'h0, rd, er);
        check_eq("nolk_adr2_rd", 64'(rd), 64'h5555_0000);
`endif

        // Reset in WAIT_IDLE aborts the commit
        pipe_idle_i = 1'b0;
        access(1'b1, I_CTRL, 32'h1, rd, er);
        check_eq("rw_hold", 64'(cfg_hold_o), 64'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_eq("rw_hold_rst", 64'(cfg_hold_o), 64'd0);
        check_eq("rw_upd_rst", 64'(cfg_updated_o), 64'd0);
        check_eq("rw_adr_o3", 64'(pma_adr_o[3]), 64'd0);
        check_eq("rw_cfg_o3", 64'(pma_cfg_o[3]), 64'd0);
        pipe_idle_i = 1'b1;
        access(1'b0, PMA_CNT+3, 32'h0, rd, er);
        check_eq("rw_shadow_adr3", 64'(rd), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rw_no_commit", 64'(cfg_hold_o | cfg_updated_o), 64'd0);
        end
        access(1'b0, I_CTRL, 32'h0, rd, er);
        check_eq("rw_ctrl_rd", 64'(rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
